// File: rtl/usb_in_ep_buf_if.sv
// Signal bundle between a USB IN endpoint buffer (slave) and the client endpoint plus
// the protocol engine that drive it (master).
interface usb_in_ep_buf_if;
  logic       in_ep_req;
  logic       in_ep_grant;
  logic       in_ep_data_free;
  logic       in_ep_data_put;
  logic [7:0] in_ep_data;
  logic       in_ep_data_done;
  logic       in_ep_stall;
  logic       in_ep_acked;
  logic       in_tok_start;
  logic       setup_tok;
  logic       rx_ack;
  logic       ep_ready;
  logic       ep_stalled;
  logic       data_toggle;
  logic       tx_data_avail;
  logic       tx_data_get;
  logic [7:0] tx_data;

  modport slave (
    input  in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
           in_tok_start, setup_tok, rx_ack, tx_data_get,
    output in_ep_grant, in_ep_data_free, in_ep_acked, ep_ready, ep_stalled,
           data_toggle, tx_data_avail, tx_data
  );

  modport master (
    output in_ep_req, in_ep_data_put, in_ep_data, in_ep_data_done, in_ep_stall,
           in_tok_start, setup_tok, rx_ack, tx_data_get,
    input  in_ep_grant, in_ep_data_free, in_ep_acked, ep_ready, ep_stalled,
           data_toggle, tx_data_avail, tx_data
  );
endinterface

// File: rtl/usb_in_ep_buf.sv
// Single-packet USB IN endpoint buffer with DATA0/1 toggle, NAK/STALL and retransmit.
// Define USB_IN_EP_AUTO_COMMIT_EN to commit automatically when the buffer fills.
module usb_in_ep_buf #(
  parameter  int MAX_PKT_SIZE = 32,
  localparam int CW           = $clog2(MAX_PKT_SIZE + 1)
) (
  input  logic             clk,
  input  logic             reset,
  usb_in_ep_buf_if.slave   ep
);

  localparam int            AW       = $clog2(MAX_PKT_SIZE);
  localparam logic [CW-1:0] MAX_CNT  = CW'(MAX_PKT_SIZE);
  localparam logic [CW-1:0] LAST_CNT = CW'(MAX_PKT_SIZE - 1);

  typedef enum logic [1:0] {S_FILL, S_READY, S_SENDING, S_STALL} state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] wr_cnt_q, wr_cnt_d;
  logic [CW-1:0] rd_ptr_q, rd_ptr_d;
  logic          toggle_q, toggle_d;
  logic          grant_q, grant_d;
  logic          acked_q, acked_d;
  logic [7:0]    mem_q [MAX_PKT_SIZE];

  logic data_free;
  logic tx_avail;
  logic wr_acc;
  logic wr_en;

  assign data_free = (state_q == S_FILL) && (wr_cnt_q < MAX_CNT);
  assign tx_avail  = (state_q == S_SENDING) && (rd_ptr_q < wr_cnt_q);
  assign wr_acc    = ep.in_ep_data_put && grant_q && data_free;
  assign grant_d   = ep.in_ep_req;

  // Handshake events are prioritised: setup > stall > ack > token > client activity.
  always_comb begin
    state_d  = state_q;
    wr_cnt_d = wr_cnt_q;
    rd_ptr_d = rd_ptr_q;
    toggle_d = toggle_q;
    acked_d  = 1'b0;
    wr_en    = 1'b0;
    if (ep.setup_tok) begin
      state_d  = S_FILL;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      toggle_d = 1'b1;
    end else if (ep.in_ep_stall) begin
      state_d  = S_STALL;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
    end else if (ep.rx_ack && (state_q == S_SENDING)) begin
      state_d  = S_FILL;
      wr_cnt_d = '0;
      rd_ptr_d = '0;
      toggle_d = ~toggle_q;
      acked_d  = 1'b1;
    end else if (ep.in_tok_start && ((state_q == S_READY) || (state_q == S_SENDING))) begin
      // A token while already sending means the host missed our data: rewind.
      state_d  = S_SENDING;
      rd_ptr_d = '0;
    end else begin
      if (ep.tx_data_get && tx_avail) begin
        rd_ptr_d = rd_ptr_q + CW'(1);
      end
      if (state_q == S_FILL) begin
        if (wr_acc) begin
          wr_en    = 1'b1;
          wr_cnt_d = wr_cnt_q + CW'(1);
        end
        if (ep.in_ep_data_done) begin
          state_d = S_READY;
        end
`ifdef USB_IN_EP_AUTO_COMMIT_EN
        if (wr_acc && (wr_cnt_q == LAST_CNT)) begin
          state_d = S_READY;
        end
`endif
      end
    end
  end

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q  <= S_FILL;
      wr_cnt_q <= '0;
      rd_ptr_q <= '0;
      toggle_q <= 1'b0;
      grant_q  <= 1'b0;
      acked_q  <= 1'b0;
    end else begin
      state_q  <= state_d;
      wr_cnt_q <= wr_cnt_d;
      rd_ptr_q <= rd_ptr_d;
      toggle_q <= toggle_d;
      grant_q  <= grant_d;
      acked_q  <= acked_d;
    end
  end

  // Packet storage carries no reset; wr_cnt/rd_ptr define what is valid.
  always_ff @(posedge clk) begin
    if (wr_en) begin
      mem_q[wr_cnt_q[AW-1:0]] <= ep.in_ep_data;
    end
  end

  assign ep.in_ep_grant     = grant_q;
  assign ep.in_ep_data_free = data_free;
  assign ep.in_ep_acked     = acked_q;
  assign ep.ep_ready        = (state_q == S_READY) || (state_q == S_SENDING);
  assign ep.ep_stalled      = (state_q == S_STALL);
  assign ep.data_toggle     = toggle_q;
  assign ep.tx_data_avail   = tx_avail;
  assign ep.tx_data         = mem_q[rd_ptr_q[AW-1:0]];

endmodule

// File: tb/tb_usb_in_ep_buf.sv
// Directed bench for usb_in_ep_buf: a 32-byte instance for the main flows and an
// 8-byte instance for the full-buffer behaviour (with or without USB_IN_EP_AUTO_COMMIT_EN).
module tb_usb_in_ep_buf;

`ifdef USB_IN_EP_AUTO_COMMIT_EN
  localparam bit AUTO = 1'b1;
`else
  localparam bit AUTO = 1'b0;
`endif

  logic clk = 1'b0;
  logic reset;
  int   checks   = 0;
  int   failures = 0;

  usb_in_ep_buf_if a_if ();
  usb_in_ep_buf_if b_if ();

  usb_in_ep_buf #(.MAX_PKT_SIZE(32)) dut_a (.clk(clk), .reset(reset), .ep(a_if));
  usb_in_ep_buf #(.MAX_PKT_SIZE(8))  dut_b (.clk(clk), .reset(reset), .ep(b_if));

  always #5 clk = ~clk;

  task automatic chk1(input string tag, input logic obs, input logic exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
    checks++;
    assert (obs === exp) else begin
      failures++;
      $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  // Drive one cycle of inputs on instance A (sel=0) or B (sel=1), then release pulses.
  task automatic step(input bit sel, input bit put, input logic [7:0] d, input bit tok,
                      input bit ack, input bit done, input bit setup, input bit stall,
                      input bit get);
    if (sel) begin
      b_if.in_ep_data_put = put;  b_if.in_ep_data = d;      b_if.in_tok_start = tok;
      b_if.rx_ack = ack;          b_if.in_ep_data_done = done; b_if.setup_tok = setup;
      b_if.in_ep_stall = stall;   b_if.tx_data_get = get;
    end else begin
      a_if.in_ep_data_put = put;  a_if.in_ep_data = d;      a_if.in_tok_start = tok;
      a_if.rx_ack = ack;          a_if.in_ep_data_done = done; a_if.setup_tok = setup;
      a_if.in_ep_stall = stall;   a_if.tx_data_get = get;
    end
    tick();
    if (sel) begin
      b_if.in_ep_data_put = 0; b_if.in_tok_start = 0; b_if.rx_ack = 0; b_if.in_ep_data_done = 0;
      b_if.setup_tok = 0; b_if.in_ep_stall = 0; b_if.tx_data_get = 0;
    end else begin
      a_if.in_ep_data_put = 0; a_if.in_tok_start = 0; a_if.rx_ack = 0; a_if.in_ep_data_done = 0;
      a_if.setup_tok = 0; a_if.in_ep_stall = 0; a_if.tx_data_get = 0;
    end
  endtask

  task automatic put_b(input bit sel, input logic [7:0] d); step(sel, 1, d, 0, 0, 0, 0, 0, 0); endtask
  task automatic tok(input bit sel);   step(sel, 0, 8'h00, 1, 0, 0, 0, 0, 0); endtask
  task automatic ack(input bit sel);   step(sel, 0, 8'h00, 0, 1, 0, 0, 0, 0); endtask
  task automatic done(input bit sel);  step(sel, 0, 8'h00, 0, 0, 1, 0, 0, 0); endtask
  task automatic setup(input bit sel); step(sel, 0, 8'h00, 0, 0, 0, 1, 0, 0); endtask
  task automatic stall(input bit sel); step(sel, 0, 8'h00, 0, 0, 0, 0, 1, 0); endtask

  task automatic pop(input bit sel, input string tag, input logic [7:0] exp);
    chk8(tag, sel ? b_if.tx_data : a_if.tx_data, exp);
    chk1({tag, "_avail"}, sel ? b_if.tx_data_avail : a_if.tx_data_avail, 1'b1);
    step(sel, 0, 8'h00, 0, 0, 0, 0, 0, 1);
  endtask

  initial begin
    reset = 1'b1;
    a_if.in_ep_req = 0; b_if.in_ep_req = 0; a_if.in_ep_data = 8'h00; b_if.in_ep_data = 8'h00;
    a_if.in_ep_data_put = 0; a_if.in_tok_start = 0; a_if.rx_ack = 0; a_if.in_ep_data_done = 0;
    a_if.setup_tok = 0; a_if.in_ep_stall = 0; a_if.tx_data_get = 0;
    b_if.in_ep_data_put = 0; b_if.in_tok_start = 0; b_if.rx_ack = 0; b_if.in_ep_data_done = 0;
    b_if.setup_tok = 0; b_if.in_ep_stall = 0; b_if.tx_data_get = 0;
    repeat (3) tick();
    reset = 1'b0;
    tick();

    // Reset state
    chk1("rst_grant",  a_if.in_ep_grant,     1'b0);
    chk1("rst_acked",  a_if.in_ep_acked,     1'b0);
    chk1("rst_ready",  a_if.ep_ready,        1'b0);
    chk1("rst_stall",  a_if.ep_stalled,      1'b0);
    chk1("rst_toggle", a_if.data_toggle,     1'b0);
    chk1("rst_avail",  a_if.tx_data_avail,   1'b0);
    chk1("rst_free",   a_if.in_ep_data_free, 1'b1);

    // Grant lags request by one cycle
    a_if.in_ep_req = 1; b_if.in_ep_req = 1;
    #1;
    chk1("grant_lag0", a_if.in_ep_grant, 1'b0);
    tick();
    chk1("grant_lag1", a_if.in_ep_grant, 1'b1);

    // 18-byte packet, full transmit, ACK
    for (int i = 0; i < 18; i++) put_b(0, (i == 0) ? 8'h12 : 8'(i));
    chk1("t1_ready_pre", a_if.ep_ready, 1'b0);
    done(0);
    chk1("t1_ready", a_if.ep_ready, 1'b1);
    chk1("t1_free",  a_if.in_ep_data_free, 1'b0);
    chk1("t1_avail_ready", a_if.tx_data_avail, 1'b0);
    tok(0);
    for (int i = 0; i < 18; i++) pop(0, "t1_byte", (i == 0) ? 8'h12 : 8'(i));
    chk1("t1_avail_end", a_if.tx_data_avail, 1'b0);
    chk1("t1_ready_send", a_if.ep_ready, 1'b1);
    chk1("t1_toggle_pre", a_if.data_toggle, 1'b0);
    ack(0);
    chk1("t1_acked",  a_if.in_ep_acked, 1'b1);
    chk1("t1_toggle", a_if.data_toggle, 1'b1);
    chk1("t1_ready_after", a_if.ep_ready, 1'b0);
    tick();
    chk1("t1_acked_pulse", a_if.in_ep_acked, 1'b0);
    chk1("t1_free_after", a_if.in_ep_data_free, 1'b1);

    // NAK on empty FILL, then zero-length packet
    tok(0);
    chk1("zlp_nak_ready", a_if.ep_ready, 1'b0);
    chk1("zlp_nak_avail", a_if.tx_data_avail, 1'b0);
    done(0);
    chk1("zlp_ready", a_if.ep_ready, 1'b1);
    tok(0);
    chk1("zlp_ready_send", a_if.ep_ready, 1'b1);
    chk1("zlp_avail", a_if.tx_data_avail, 1'b0);
    ack(0);
    chk1("zlp_acked",  a_if.in_ep_acked, 1'b1);
    chk1("zlp_toggle", a_if.data_toggle, 1'b0);

    // STALL from READY, held until SETUP
    put_b(0, 8'h55); put_b(0, 8'h66); done(0);
    chk1("st_ready_pre", a_if.ep_ready, 1'b1);
    stall(0);
    chk1("st_stalled", a_if.ep_stalled, 1'b1);
    chk1("st_ready",   a_if.ep_ready, 1'b0);
    chk1("st_free",    a_if.in_ep_data_free, 1'b0);
    tok(0);
    chk1("st_tok_ready", a_if.ep_ready, 1'b0);
    chk1("st_tok_avail", a_if.tx_data_avail, 1'b0);
    chk1("st_tok_stalled", a_if.ep_stalled, 1'b1);
    ack(0);
    chk1("st_ack_ignored", a_if.in_ep_acked, 1'b0);
    chk1("st_ack_toggle",  a_if.data_toggle, 1'b0);
    setup(0);
    chk1("st_setup_stalled", a_if.ep_stalled, 1'b0);
    chk1("st_setup_toggle",  a_if.data_toggle, 1'b1);
    chk1("st_setup_free",    a_if.in_ep_data_free, 1'b1);
    chk1("st_setup_ready",   a_if.ep_ready, 1'b0);

    // Retransmit when ACK is missing
    for (int i = 0; i < 4; i++) put_b(0, 8'(8'hA0 + i));
    done(0);
    tok(0);
    for (int i = 0; i < 4; i++) pop(0, "rt_first", 8'(8'hA0 + i));
    chk1("rt_avail_end", a_if.tx_data_avail, 1'b0);
    tok(0);
    chk1("rt_toggle_kept", a_if.data_toggle, 1'b1);
    for (int i = 0; i < 4; i++) pop(0, "rt_resend", 8'(8'hA0 + i));
    chk1("rt_avail_end2", a_if.tx_data_avail, 1'b0);
    ack(0);
    chk1("rt_acked",  a_if.in_ep_acked, 1'b1);
    chk1("rt_toggle", a_if.data_toggle, 1'b0);

    // Put and commit in the same cycle; a put outside FILL is dropped
    put_b(0, 8'hC0); put_b(0, 8'hC1);
    step(0, 1, 8'hC2, 0, 0, 1, 0, 0, 0);
    chk1("pd_ready", a_if.ep_ready, 1'b1);
    put_b(0, 8'hFF);
    tok(0);
    for (int i = 0; i < 3; i++) pop(0, "pd_byte", 8'(8'hC0 + i));
    chk1("pd_len3", a_if.tx_data_avail, 1'b0);

    // SETUP and ACK together while sending: SETUP wins
    step(0, 0, 8'h00, 0, 1, 0, 1, 0, 0);
    chk1("sa_acked",  a_if.in_ep_acked, 1'b0);
    chk1("sa_toggle", a_if.data_toggle, 1'b1);
    chk1("sa_ready",  a_if.ep_ready, 1'b0);
    chk1("sa_free",   a_if.in_ep_data_free, 1'b1);
    tick();
    chk1("sa_acked_late", a_if.in_ep_acked, 1'b0);

    // 8-byte instance: write 10 bytes into a full buffer
    for (int i = 0; i < 10; i++) begin
      chk1("fb_free", b_if.in_ep_data_free, (i < 8) ? 1'b1 : 1'b0);
      put_b(1, 8'(8'h80 + i));
      if (i == 7) chk1("fb_autocommit", b_if.ep_ready, AUTO);
    end
    chk1("fb_free_full", b_if.in_ep_data_free, 1'b0);
    if (!AUTO) done(1);
    chk1("fb_ready", b_if.ep_ready, 1'b1);
    tok(1);
    for (int i = 0; i < 8; i++) pop(1, "fb_byte", 8'(8'h80 + i));
    chk1("fb_avail_end", b_if.tx_data_avail, 1'b0);
    chk1("fb_free_send", b_if.in_ep_data_free, 1'b0);
    ack(1);
    chk1("fb_acked",  b_if.in_ep_acked, 1'b1);
    chk1("fb_toggle", b_if.data_toggle, 1'b1);
    chk1("fb_free_ack", b_if.in_ep_data_free, 1'b1);
    put_b(1, 8'h88); put_b(1, 8'h89);
    chk1("fb2_ready_pre", b_if.ep_ready, 1'b0);
    done(1);
    chk1("fb2_ready", b_if.ep_ready, 1'b1);
    tok(1);
    pop(1, "fb2_byte", 8'h88);
    pop(1, "fb2_byte", 8'h89);
    chk1("fb2_len2", b_if.tx_data_avail, 1'b0);
    chk1("fb2_toggle", b_if.data_toggle, 1'b1);

    // Reset while sending discards the packet without an ACK pulse
    reset = 1'b1;
    tick();
    reset = 1'b0;
    chk1("rs_acked",  b_if.in_ep_acked, 1'b0);
    chk1("rs_ready",  b_if.ep_ready, 1'b0);
    chk1("rs_toggle", b_if.data_toggle, 1'b0);
    chk1("rs_avail",  b_if.tx_data_avail, 1'b0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/usb_in_ep_buf.md
Name: usb_in_ep_buf

Overview:
- Single-packet IN endpoint buffer with two sides.
  - Client side: a function endpoint such as a control or vendor endpoint. It writes bytes, commits a packet, and requests stall.
  - Protocol side: the USB FS protocol engine. It reads the committed packet on an IN token and reports the host handshake.
- Owns DATA0/DATA1 toggle, NAK/STALL indication and retransmit-on-missing-ACK.
- One instance per IN endpoint.

Parameters:
- MAX_PKT_SIZE, 32, buffer depth and max payload in bytes; legal values 8/16/32/64.
- CW, $clog2(MAX_PKT_SIZE+1), width of byte counters (derived; do not override).

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- in_ep_req  in  1  client requests buffer access
- in_ep_grant  out  1  access granted, registered
- in_ep_data_free  out  1  buffer can accept a byte this cycle
- in_ep_data_put  in  1  write in_ep_data this cycle
- in_ep_data  in  8  byte to write
- in_ep_data_done  in  1  pulse: commit packet (may be zero-length)
- in_ep_stall  in  1  pulse: enter STALL
- in_ep_acked  out  1  1-cycle pulse: host ACKed the packet
- in_tok_start  in  1  pulse: IN token for this endpoint decoded
- setup_tok  in  1  pulse: SETUP token for this endpoint decoded
- rx_ack  in  1  pulse: host ACK handshake received
- ep_ready  out  1  committed packet available (protocol sends DATAx, else NAK)
- ep_stalled  out  1  protocol returns STALL handshake
- data_toggle  out  1  PID to send: 0 = DATA0, 1 = DATA1
- tx_data_avail  out  1  unread bytes remain in current transmission
- tx_data_get  in  1  pop tx_data
- tx_data  out  8  byte at read pointer, combinational from buffer

Behaviour:
- States: FILL, READY, SENDING, STALL. Reset state is FILL.
- Reset values: in_ep_grant=0, in_ep_acked=0, ep_ready=0, ep_stalled=0, data_toggle=0, tx_data_avail=0, wr_cnt=0, rd_ptr=0.
- Grant: in_ep_grant <= in_ep_req each cycle, so grant lags req by one cycle.
- data_free = (state==FILL) && (wr_cnt < MAX_PKT_SIZE).
- Write: accepted when put && grant && data_free. Effect: buf[wr_cnt] <= data, wr_cnt++. A put while !data_free is dropped silently.
- Commit (FILL->READY), registered:
  - On in_ep_data_done.
  - If put is accepted in the same cycle as data_done, that byte is included.
  - Commit with wr_cnt==0 produces a zero-length packet.
  - in_ep_data_done outside FILL is ignored.
- ep_ready = (state==READY) || (state==SENDING).
- READY->SENDING on in_tok_start. rd_ptr=0.
- tx_data_avail = (state==SENDING) && (rd_ptr < wr_cnt).
- tx_data = buf[rd_ptr]. tx_data_get while avail increments rd_ptr; tx_data_get while !avail is ignored.
- SENDING + rx_ack:
  - data_toggle flips; in_ep_acked pulses for 1 cycle; wr_cnt=0, rd_ptr=0; state becomes FILL.
- SENDING + in_tok_start without a prior rx_ack (host missed our data): rd_ptr=0, data_toggle unchanged, retransmit the same packet.
- rx_ack in any state other than SENDING is ignored.
- in_tok_start in FILL: no state change; ep_ready=0, so the protocol engine NAKs.
- Stall:
  - in_ep_stall in any state forces STALL: ep_stalled=1, buffer cleared, ep_ready=0.
  - STALL is left only via setup_tok or reset.
- setup_tok, any state: state=FILL, wr_cnt=0, rd_ptr=0, ep_stalled=0, data_toggle=1 (first data/status stage after SETUP is DATA1).
- Priority in the same cycle: reset > setup_tok > in_ep_stall > rx_ack > in_tok_start > client commit/write.
- Reset mid-SENDING discards the packet; no in_ep_acked pulse.

Optional Feature:
- Macro: USB_IN_EP_AUTO_COMMIT_EN.
- Defined: an accepted put that makes wr_cnt==MAX_PKT_SIZE also commits (FILL->READY) in the same cycle. Client streams long transfers and pulses data_done only for the final short packet; a full final packet needs data_done followed by a zero-length packet.
- Undefined: a full buffer only deasserts data_free; commit happens solely on in_ep_data_done.

Test Plan:
- Write 18 bytes 0x12,0x01,...; pulse data_done; in_tok_start; pop all; rx_ack.
  - Expect: tx_data sequence identical; tx_data_avail falls after byte 18.
  - Expect: data_toggle 0->1; in_ep_acked pulses 1 cycle; ep_ready=0.
- Commit 4 bytes; in_tok_start; pop 4; no ACK; second in_tok_start.
  - Expect: rd_ptr rewound; same 4 bytes resent; data_toggle unchanged.
- in_tok_start with empty FILL buffer -> ep_ready=0, tx_data_avail=0 (NAK path); then data_done with 0 bytes -> ep_ready=1, tx_data_avail=0 on token (ZLP).
- in_ep_stall during READY -> ep_stalled=1, ep_ready=0; IN tokens ignored; setup_tok -> ep_stalled=0, data_toggle=1, data_free=1.
- With USB_IN_EP_AUTO_COMMIT_EN and MAX_PKT_SIZE=8, write 10 bytes.
  - Expect: auto-commit after byte 8; data_free=0 until ACK.
  - Expect: after ACK, 2 further bytes accepted; data_done commits a 2-byte packet with data_toggle=1.
  - Without the macro: no commit until data_done; bytes 9-10 dropped.
- Same-cycle put + data_done on byte 3 -> committed length 3; simultaneous setup_tok + rx_ack -> setup wins, in_ep_acked not pulsed, data_toggle=1.
